// File: rtl/lift_call_dispatcher.sv
// Two-car hall-call dispatcher: latches hall button presses into call slots,
// assigns each call to the cheaper car and clears it when that car serves it.
module lift_call_dispatcher #(
    parameter int FLOORS = 4,
    parameter int CW     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] hall_up_btn,
    input  logic [FLOORS-1:0] hall_dn_btn,
    input  logic [FLOORS-1:0] a_pos,
    input  logic [1:0]        a_dir,
    input  logic              a_door,
    input  logic [FLOORS-1:0] b_pos,
    input  logic [1:0]        b_dir,
    input  logic              b_door,
    output logic [FLOORS-1:0] a_up_req,
    output logic [FLOORS-1:0] a_dn_req,
    output logic [FLOORS-1:0] b_up_req,
    output logic [FLOORS-1:0] b_dn_req,
    output logic [FLOORS-1:0] hall_up_lamp,
    output logic [FLOORS-1:0] hall_dn_lamp,
    output logic              busy
);
    localparam int N  = 2 * FLOORS;
    localparam int PW = $clog2(N);
    localparam logic [CW-1:0] COST_MAX  = '1;
    localparam logic [N-1:0]  SLOT_ONE  = {{(N-1){1'b0}}, 1'b1};
    // Up at the top floor and down at floor 0 are not real calls.
    localparam logic [N-1:0]  SLOT_MASK = ~((SLOT_ONE << (FLOORS - 1)) | (SLOT_ONE << FLOORS));

    typedef enum logic [1:0] {IDLE, EVAL, COMMIT} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cost_a_q, cost_a_d, cost_b_q, cost_b_d;
    logic            rr_q, rr_d;
    logic [N-1:0]    sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [N-1:0]    pending_q, pending_d, assigned_q, assigned_d, owner_q, owner_d;
    logic [N-1:0]    req_a_q, req_a_d, req_b_q, req_b_d;
    logic            busy_q, busy_d;
    logic [N-1:0]    clear;

    function automatic logic [CW-1:0] car_cost(input logic [FLOORS-1:0] pos,
                                               input logic [1:0] dir,
                                               input int f, input logic call_dn);
        logic [FLOORS-1:0] sh;
        int p;
        int c;
        p = 0;
        for (int i = 0; i < FLOORS; i++) begin
            sh = pos >> i;
            if (sh[0]) p = i;
        end
        c = (f >= p) ? (f - p) : (p - f);
        // Moving away, or heading through the floor the wrong way for the call.
        if ((dir == 2'b01) && ((f < p) || call_dn))  c = c + FLOORS;
        if ((dir == 2'b10) && ((f > p) || !call_dn)) c = c + FLOORS;
        return $onehot(pos) ? c[CW-1:0] : COST_MAX;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_clear
            localparam int         FL    = gi % FLOORS;
            localparam logic [1:0] MATCH = (gi >= FLOORS) ? 2'b10 : 2'b01;
            logic a_at, b_at, a_ok, b_ok;
            assign a_at = a_door & a_pos[FL];
            assign b_at = b_door & b_pos[FL];
            assign a_ok = (a_dir == 2'b00) || (a_dir == 2'b11) || (a_dir == MATCH);
            assign b_ok = (b_dir == 2'b00) || (b_dir == 2'b11) || (b_dir == MATCH);
            assign clear[gi] = assigned_q[gi] ? (owner_q[gi] ? b_at : a_at)
                                              : ((a_at & a_ok) | (b_at & b_ok));
        end
    endgenerate

    always_comb begin
        logic [N-1:0]  unserved;
        logic [PW-1:0] cand;
        logic          found;
        logic          win;
        logic          slot_dn;
        int            sf;

        state_d    = state_q;
        ptr_d      = ptr_q;
        cost_a_d   = cost_a_q;
        cost_b_d   = cost_b_q;
        rr_d       = rr_q;
        sync1_d    = {hall_dn_btn, hall_up_btn};
        sync2_d    = sync1_q;
        sync3_d    = sync2_q;
        pending_d  = pending_q | (sync2_q & ~sync3_q & SLOT_MASK);
        assigned_d = assigned_q;
        owner_d    = owner_q;
        unserved   = pending_q & ~assigned_q;
        cand       = '0;
        found      = 1'b0;
        win        = 1'b0;
        slot_dn    = (int'(ptr_q) >= FLOORS);
        sf         = slot_dn ? (int'(ptr_q) - FLOORS) : int'(ptr_q);

        case (state_q)
            IDLE: begin
                for (int k = 1; k <= N; k++) begin
                    cand = PW'((int'(ptr_q) + k) % N);
                    if (!found && unserved[cand]) begin
                        found = 1'b1;
                        ptr_d = cand;
                    end
                end
                if (found) state_d = EVAL;
            end
            EVAL: begin
                cost_a_d = car_cost(a_pos, a_dir, sf, slot_dn);
                cost_b_d = car_cost(b_pos, b_dir, sf, slot_dn);
                state_d  = COMMIT;
            end
            COMMIT: begin
                state_d = IDLE;
                if (unserved[ptr_q] && !((cost_a_q == COST_MAX) && (cost_b_q == COST_MAX))) begin
                    if (cost_a_q < cost_b_q) begin
                        win = 1'b0;
                    end else if (cost_b_q < cost_a_q) begin
                        win = 1'b1;
                    end else begin
                        win  = rr_q;
                        rr_d = ~rr_q;
                    end
                    assigned_d[ptr_q] = 1'b1;
                    owner_d[ptr_q]    = win;
                end
            end
            default: state_d = IDLE;
        endcase

        // Service overrides both a fresh press and a commit in the same cycle.
        pending_d  = pending_d & ~clear;
        assigned_d = assigned_d & ~clear;
        owner_d    = owner_d & ~clear;
        req_a_d    = pending_d & assigned_d & ~owner_d;
        req_b_d    = pending_d & assigned_d & owner_d;
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cost_a_q   <= '0;
            cost_b_q   <= '0;
            rr_q       <= 1'b0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync3_q    <= '0;
            pending_q  <= '0;
            assigned_q <= '0;
            owner_q    <= '0;
            req_a_q    <= '0;
            req_b_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cost_a_q   <= cost_a_d;
            cost_b_q   <= cost_b_d;
            rr_q       <= rr_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync3_q    <= sync3_d;
            pending_q  <= pending_d;
            assigned_q <= assigned_d;
            owner_q    <= owner_d;
            req_a_q    <= req_a_d;
            req_b_q    <= req_b_d;
            busy_q     <= busy_d;
        end
    end

    assign hall_up_lamp = pending_q[FLOORS-1:0];
    assign hall_dn_lamp = pending_q[N-1:FLOORS];
    assign a_up_req     = req_a_q[FLOORS-1:0];
    assign a_dn_req     = req_a_q[N-1:FLOORS];
    assign b_up_req     = req_b_q[FLOORS-1:0];
    assign b_dn_req     = req_b_q[N-1:FLOORS];
    assign busy         = busy_q;
endmodule

// File: tb/tb_lift_call_dispatcher.sv
// Bench for lift_call_dispatcher: directed scenarios plus a randomized run
// against a floor-number based reference model of the dispatcher.
module tb_lift_call_dispatcher;
    localparam int F    = 4;
    localparam int N    = 2 * F;
    localparam int MAXC = 15;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [F-1:0] hall_up_btn, hall_dn_btn, a_pos, b_pos;
    logic [1:0]   a_dir, b_dir;
    logic         a_door, b_door;
    logic [F-1:0] a_up_req, a_dn_req, b_up_req, b_dn_req, hall_up_lamp, hall_dn_lamp;
    logic         busy;

    int checks = 0;
    int failures = 0;

    lift_call_dispatcher #(.FLOORS(F), .CW(4)) dut (
        .clk(clk), .reset(reset),
        .hall_up_btn(hall_up_btn), .hall_dn_btn(hall_dn_btn),
        .a_pos(a_pos), .a_dir(a_dir), .a_door(a_door),
        .b_pos(b_pos), .b_dir(b_dir), .b_door(b_door),
        .a_up_req(a_up_req), .a_dn_req(a_dn_req),
        .b_up_req(b_up_req), .b_dn_req(b_dn_req),
        .hall_up_lamp(hall_up_lamp), .hall_dn_lamp(hall_dn_lamp),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: calls as arrays, dispatcher as a 0/1/2 phase counter.
    bit           m_pend[N], m_asg[N], m_own[N];
    int           m_phase, m_ptr, m_ca, m_cb;
    bit           m_rr;
    logic [N-1:0] h1, h2, h3;
    logic [F-1:0] e_up_lamp, e_dn_lamp, e_a_up, e_a_dn, e_b_up, e_b_dn;
    logic         e_busy;

    function automatic int floor_of(input logic [F-1:0] pos);
        int fl;
        fl = -1;
        if ($countones(pos) == 1)
            for (int i = 0; i < F; i++) if (pos[i]) fl = i;
        return fl;
    endfunction

    function automatic int mcost(input logic [F-1:0] pos, input logic [1:0] dir,
                                 input int f, input bit down);
        int p, c, motion, want;
        p = floor_of(pos);
        if (p < 0) return MAXC;
        c = (f > p) ? f - p : p - f;
        motion = (dir == 2'b01) ? 1 : (dir == 2'b10) ? -1 : 0;
        want = down ? -1 : 1;
        if (motion != 0 && (((f - p) * motion) < 0 || motion != want)) c = c + F;
        return c;
    endfunction

    task automatic model_outputs();
        for (int i = 0; i < F; i++) begin
            e_up_lamp[i] = m_pend[i];
            e_dn_lamp[i] = m_pend[i+F];
            e_a_up[i] = m_pend[i] && m_asg[i] && !m_own[i];
            e_a_dn[i] = m_pend[i+F] && m_asg[i+F] && !m_own[i+F];
            e_b_up[i] = m_pend[i] && m_asg[i] && m_own[i];
            e_b_dn[i] = m_pend[i+F] && m_asg[i+F] && m_own[i+F];
        end
        e_busy = (m_phase != 0);
    endtask

    task automatic model_reset();
        for (int s = 0; s < N; s++) begin
            m_pend[s] = 0; m_asg[s] = 0; m_own[s] = 0;
        end
        m_phase = 0; m_ptr = 0; m_ca = 0; m_cb = 0; m_rr = 0;
        h1 = '0; h2 = '0; h3 = '0;
        model_outputs();
    endtask

    task automatic model_step();
        bit np[N], na[N], no[N];
        bit found, win, dn, a_at, b_at, a_ok, b_ok, clr;
        int fl, nptr, cidx;
        np = m_pend; na = m_asg; no = m_own;
        for (int s = 0; s < N; s++) begin
            fl = s % F; dn = (s >= F);
            if ((dn ? fl != 0 : fl != F - 1) && h2[s] && !h3[s]) np[s] = 1;
        end
        case (m_phase)
            0: begin
                found = 0; nptr = m_ptr;
                for (int k = 1; k <= N; k++) begin
                    cidx = (m_ptr + k) % N;
                    if (!found && m_pend[cidx] && !m_asg[cidx]) begin
                        found = 1; nptr = cidx;
                    end
                end
                m_ptr = nptr;
                if (found) m_phase = 1;
            end
            1: begin
                m_ca = mcost(a_pos, a_dir, m_ptr % F, m_ptr >= F);
                m_cb = mcost(b_pos, b_dir, m_ptr % F, m_ptr >= F);
                m_phase = 2;
            end
            default: begin
                if (m_pend[m_ptr] && !m_asg[m_ptr] && !(m_ca == MAXC && m_cb == MAXC)) begin
                    if (m_ca != m_cb) win = (m_cb < m_ca);
                    else begin win = m_rr; m_rr = !m_rr; end
                    na[m_ptr] = 1; no[m_ptr] = win;
                end
                m_phase = 0;
            end
        endcase
        for (int s = 0; s < N; s++) begin
            fl = s % F; dn = (s >= F);
            a_at = a_door && a_pos[fl];
            b_at = b_door && b_pos[fl];
            a_ok = (a_dir == 2'b00) || (a_dir == 2'b11) || (a_dir == (dn ? 2'b10 : 2'b01));
            b_ok = (b_dir == 2'b00) || (b_dir == 2'b11) || (b_dir == (dn ? 2'b10 : 2'b01));
            clr = m_asg[s] ? (m_own[s] ? b_at : a_at) : ((a_at && a_ok) || (b_at && b_ok));
            if (clr) begin np[s] = 0; na[s] = 0; no[s] = 0; end
        end
        m_pend = np; m_asg = na; m_own = no;
        h3 = h2; h2 = h1; h1 = {hall_dn_btn, hall_up_btn};
        model_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (!reset) model_step();
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        hall_up_btn = '0; hall_dn_btn = '0;
        a_dir = 2'b00; b_dir = 2'b00; a_door = 1'b0; b_door = 1'b0;
        model_reset();
        run(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        hall_up_btn = '0; hall_dn_btn = '0; a_pos = 4'b0001; b_pos = 4'b1000;
        a_dir = 2'b00; b_dir = 2'b00; a_door = 1'b0; b_door = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({a_up_req, a_dn_req, b_up_req, b_dn_req, hall_up_lamp, hall_dn_lamp} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {a_up_req, a_dn_req, b_up_req, b_dn_req, hall_up_lamp, hall_dn_lamp});
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        run(2);
        reset = 1'b0;
        run(4);
        checks++;
        if ({hall_up_lamp, hall_dn_lamp, busy} !== '0) begin
            failures++; $display("FAIL idle_after_reset: got %b expected zero", {hall_up_lamp, hall_dn_lamp, busy});
        end
        $display("test_reset: lamps=%b/%b busy=%b", hall_up_lamp, hall_dn_lamp, busy);
    endtask

    task automatic test_assign();
        do_reset();
        a_pos = 4'b0001; b_pos = 4'b1000;
        hall_up_btn = 4'b0010;
        run(2);
        checks++;
        if (hall_up_lamp !== 4'b0000) begin failures++; $display("FAIL lamp_edge2: got %b expected 0000", hall_up_lamp); end
        run(1);
        checks++;
        if (hall_up_lamp !== 4'b0010) begin failures++; $display("FAIL lamp_edge3: got %b expected 0010", hall_up_lamp); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL busy_edge3: got %b expected 0", busy); end
        run(1);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL busy_eval: got %b expected 1", busy); end
        run(1);
        checks++;
        if ({busy, a_up_req} !== 5'b10000) begin failures++; $display("FAIL busy_commit: got %b expected 10000", {busy, a_up_req}); end
        run(1);
        checks++;
        if ({busy, a_up_req, b_up_req} !== 9'b0_0010_0000) begin
            failures++; $display("FAIL assign_near_a: got %b expected 000100000", {busy, a_up_req, b_up_req});
        end
        hall_up_btn = '0;
        $display("test_assign: up[1] a_up=%b b_up=%b", a_up_req, b_up_req);
    endtask

    task automatic test_tie();
        do_reset();
        a_pos = 4'b0001; b_pos = 4'b0100;
        hall_dn_btn = 4'b0100; run(1); hall_dn_btn = '0; run(7);
        checks++;
        if ({a_dn_req, b_dn_req} !== 8'b0000_0100) begin
            failures++; $display("FAIL dn2_to_b: got %b expected 00000100", {a_dn_req, b_dn_req});
        end
        hall_up_btn = 4'b0010; run(1); hall_up_btn = '0; run(7);
        checks++;
        if ({a_up_req, b_up_req} !== 8'b0010_0000) begin
            failures++; $display("FAIL tie1_to_a: got %b expected 00100000", {a_up_req, b_up_req});
        end
        hall_dn_btn = 4'b0010; run(1); hall_dn_btn = '0; run(7);
        checks++;
        if ({a_dn_req, b_dn_req} !== 8'b0000_0110) begin
            failures++; $display("FAIL tie2_to_b: got %b expected 00000110", {a_dn_req, b_dn_req});
        end
        $display("test_tie: a_up=%b b_dn=%b", a_up_req, b_dn_req);
    endtask

    task automatic test_direction();
        do_reset();
        a_pos = 4'b0100; a_dir = 2'b10; b_pos = 4'b0001;
        hall_up_btn = 4'b0100; run(1); hall_up_btn = '0; run(7);
        checks++;
        if ({a_up_req, b_up_req} !== 8'b0000_0100) begin
            failures++; $display("FAIL dir_penalty: got %b expected 00000100", {a_up_req, b_up_req});
        end
        a_dir = 2'b00;
        $display("test_direction: a_up=%b b_up=%b", a_up_req, b_up_req);
    endtask

    task automatic test_service();
        do_reset();
        a_pos = 4'b0001; b_pos = 4'b1000;
        hall_up_btn = 4'b0010; run(1); hall_up_btn = '0; run(7);
        checks++;
        if (a_up_req !== 4'b0010) begin failures++; $display("FAIL service_setup: got %b expected 0010", a_up_req); end
        hall_up_btn = 4'b0010;
        run(2);
        a_door = 1'b1; a_pos = 4'b0010;
        run(1);
        checks++;
        if ({a_up_req, hall_up_lamp} !== 8'b0000_0000) begin
            failures++; $display("FAIL service_clear: got %b expected 00000000", {a_up_req, hall_up_lamp});
        end
        a_door = 1'b0; hall_up_btn = '0;
        run(5);
        checks++;
        if ({hall_up_lamp, busy} !== 5'b00000) begin
            failures++; $display("FAIL no_relatch: got %b expected 00000", {hall_up_lamp, busy});
        end
        $display("test_service: lamp=%b a_up=%b", hall_up_lamp, a_up_req);
    endtask

    task automatic test_ignored();
        do_reset();
        hall_up_btn = 4'b1000; hall_dn_btn = 4'b0001;
        run(6);
        checks++;
        if ({hall_up_lamp, hall_dn_lamp, busy} !== 9'b0) begin
            failures++; $display("FAIL ignored_bits: got %b expected 000000000", {hall_up_lamp, hall_dn_lamp, busy});
        end
        hall_up_btn = '0; hall_dn_btn = '0;
        $display("test_ignored: lamps=%b/%b", hall_up_lamp, hall_dn_lamp);
    endtask

    task automatic test_invalid_pos();
        logic [4*F-1:0] seen;
        do_reset();
        a_pos = 4'b0000; b_pos = 4'b0110;
        hall_up_btn = 4'b0001; run(1); hall_up_btn = '0; run(2);
        checks++;
        if (hall_up_lamp !== 4'b0001) begin failures++; $display("FAIL invalid_lamp: got %b expected 0001", hall_up_lamp); end
        seen = '0;
        for (int i = 0; i < 24; i++) begin
            run(1);
            seen = seen | {a_up_req, a_dn_req, b_up_req, b_dn_req};
        end
        checks++;
        if ({seen, hall_up_lamp} !== {16'h0000, 4'b0001}) begin
            failures++; $display("FAIL invalid_no_req: got %b expected 00000000000000000001", {seen, hall_up_lamp});
        end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({hall_up_lamp, busy} !== 5'b00000) begin
            failures++; $display("FAIL async_reset: got %b expected 00000", {hall_up_lamp, busy});
        end
        run(1);
        reset = 1'b0;
        a_pos = 4'b0001; b_pos = 4'b1000;
        $display("test_invalid_pos: lamp=%b busy=%b", hall_up_lamp, busy);
    endtask

    task automatic test_random();
        int r;
        logic [F-1:0] one;
        one = 4'b0001;
        do_reset();
        a_pos = 4'b0001; b_pos = 4'b1000;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            if ($urandom_range(0, 2) == 0) hall_up_btn = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 2) == 0) hall_dn_btn = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, 19);
                a_pos = (r == 0) ? 4'b0000 : (r == 1) ? 4'b0110 : (one << (r % F));
            end
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, 19);
                b_pos = (r == 0) ? 4'b0000 : (r == 1) ? 4'b1001 : (one << (r % F));
            end
            if ($urandom_range(0, 3) == 0) a_dir = 2'($urandom);
            if ($urandom_range(0, 3) == 0) b_dir = 2'($urandom);
            a_door = ($urandom_range(0, 6) == 0);
            b_door = ($urandom_range(0, 6) == 0);
            run(1);
            checks++;
            if ({hall_up_lamp, hall_dn_lamp} !== {e_up_lamp, e_dn_lamp}) begin
                failures++; $display("FAIL rand_lamps cyc %0d: got %b expected %b", cyc, {hall_up_lamp, hall_dn_lamp}, {e_up_lamp, e_dn_lamp});
            end
            checks++;
            if ({a_up_req, a_dn_req} !== {e_a_up, e_a_dn}) begin
                failures++; $display("FAIL rand_a_req cyc %0d: got %b expected %b", cyc, {a_up_req, a_dn_req}, {e_a_up, e_a_dn});
            end
            checks++;
            if ({b_up_req, b_dn_req} !== {e_b_up, e_b_dn}) begin
                failures++; $display("FAIL rand_b_req cyc %0d: got %b expected %b", cyc, {b_up_req, b_dn_req}, {e_b_up, e_b_dn});
            end
            checks++;
            if (busy !== e_busy) begin
                failures++; $display("FAIL rand_busy cyc %0d: got %b expected %b", cyc, busy, e_busy);
            end
            if (cyc % 200 == 199)
                $display("test_random: cyc=%0d lamps=%b/%b a=%b/%b b=%b/%b", cyc,
                         hall_up_lamp, hall_dn_lamp, a_up_req, a_dn_req, b_up_req, b_dn_req);
        end
    endtask

    initial begin
        test_reset();
        test_assign();
        test_tie();
        test_direction();
        test_service();
        test_ignored();
        test_invalid_pos();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
